// File: rtl/mac_kernel_sched_pkg.sv
// Shared types and constants for the mac kernel scheduler.
// Holds the FSM state encoding and default sizing values.
package mac_kernel_sched_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    WAIT_DONE,
    DONE,
    ABORT
  } sched_state_t;

  localparam int DEF_TIMEOUT = 1024;
  localparam int DEF_LAT_W = 16;

  // Saturation value of the default-width latency counter
  localparam logic [DEF_LAT_W-1:0] LAT_SAT = '1;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first set request strictly
// after last_grant, wrapping; the pointer lives in the caller.
module rr_arbiter #(
  parameter int N = 4
) (
  input  logic [N-1:0]         req,
  input  logic [$clog2(N)-1:0] last_grant,
  output logic [$clog2(N)-1:0] grant_idx,
  output logic                 grant_valid
);

  localparam int W = $clog2(N);

  always_comb begin
    int s;
    s = 0;
    grant_idx = '0;
    grant_valid = 1'b0;
    // Walk from farthest to nearest so the nearest hit wins
    for (int k = N; k >= 1; k--) begin
      s = int'(last_grant) + k;
      if (s >= N) s = s - N;
      if (req[s[W-1:0]]) begin
        grant_idx = s[W-1:0];
        grant_valid = 1'b1;
      end
    end
  end

endmodule

// File: rtl/mac_kernel_scheduler.sv
// Shares one ap_ctrl_chain mac kernel between NUM_REQ requesters.
// MAC_KERNEL_SCHED_PERF_EN enables the latency counters.
module mac_kernel_scheduler
  import mac_kernel_sched_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int TIMEOUT = DEF_TIMEOUT,
  parameter int LAT_W   = DEF_LAT_W
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic [NUM_REQ-1:0]         req,
  output logic [NUM_REQ-1:0]         req_done,
  output logic                       req_err,
  output logic [$clog2(NUM_REQ)-1:0] sel,
  output logic                       ap_start,
  input  logic                       ap_ready,
  input  logic                       ap_done,
  output logic                       ap_continue,
  output logic                       busy,
  output logic                       timeout_err,
  output logic [LAT_W-1:0]           last_latency,
  output logic [LAT_W-1:0]           max_latency
);

  localparam int SW  = $clog2(NUM_REQ);
  localparam int WDW = $clog2(TIMEOUT + 1);

  sched_state_t r_state;
  sched_state_t w_next;

  logic [SW-1:0]  r_sel;
  logic [SW-1:0]  r_last_grant;
  logic [SW-1:0]  w_gidx;
  logic           w_gvalid;
  logic [WDW-1:0] r_wd;
  logic           w_tmo;
  logic           w_fin;
  logic           w_run;
  logic           r_busy;
  logic           r_tmo_err;

  rr_arbiter #(.N(NUM_REQ)) u_arb (
    .req         (req),
    .last_grant  (r_last_grant),
    .grant_idx   (w_gidx),
    .grant_valid (w_gvalid)
  );

  assign w_run = (r_state == START) ||
                 (r_state == WAIT_DONE);
  assign w_tmo = (r_wd >= WDW'(TIMEOUT - 1));

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      IDLE: begin
        if (w_gvalid) w_next = START;
      end
      START: begin
        if (ap_ready && ap_done) w_next = DONE;
        else if (w_tmo && !ap_done) w_next = ABORT;
        else if (ap_ready) w_next = WAIT_DONE;
      end
      WAIT_DONE: begin
        // A done on the timeout cycle still completes cleanly
        if (ap_done) w_next = DONE;
        else if (w_tmo) w_next = ABORT;
      end
      DONE:    w_next = IDLE;
      ABORT:   w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state      <= IDLE;
      r_sel        <= '0;
      r_last_grant <= SW'(NUM_REQ - 1);
      r_wd         <= '0;
      r_busy       <= 1'b0;
      r_tmo_err    <= 1'b0;
    end else begin
      r_state <= w_next;
      r_busy  <= (w_next != IDLE);
      if (r_state == IDLE && w_gvalid) begin
        r_sel        <= w_gidx;
        r_last_grant <= w_gidx;
      end
      if (!w_run) r_wd <= '0;
      else if (r_wd != WDW'(TIMEOUT))
        r_wd <= r_wd + WDW'(1);
      if (w_next == ABORT) r_tmo_err <= 1'b1;
    end
  end

  always_comb begin
    w_fin       = (r_state == DONE) ||
                  (r_state == ABORT);
    ap_start    = (r_state == START);
    ap_continue = w_fin;
    req_err     = (r_state == ABORT);
    req_done    = '0;
    if (w_fin) req_done = NUM_REQ'(1) << r_sel;
  end

  assign sel         = r_sel;
  assign busy        = r_busy;
  assign timeout_err = r_tmo_err;

`ifdef MAC_KERNEL_SCHED_PERF_EN
  logic [LAT_W-1:0] r_lat;
  logic [LAT_W-1:0] r_last_lat;
  logic [LAT_W-1:0] r_max_lat;

  always_ff @(posedge clock) begin
    if (reset) begin
      r_lat      <= '0;
      r_last_lat <= '0;
      r_max_lat  <= '0;
    end else begin
      if (!w_run) r_lat <= '0;
      else if (r_lat != {LAT_W{1'b1}})
        r_lat <= r_lat + LAT_W'(1);
      if (r_state == DONE) begin
        r_last_lat <= r_lat;
        if (r_lat > r_max_lat) r_max_lat <= r_lat;
      end
    end
  end

  assign last_latency = r_last_lat;
  assign max_latency  = r_max_lat;
`else
  assign last_latency = '0;
  assign max_latency  = '0;
`endif

endmodule

// File: doc/mac_kernel_scheduler.md
# mac_kernel_scheduler

- Shares one HLS-generated `mac` kernel (ap_ctrl_chain: `ap_start`/`ap_ready`/`ap_done`/`ap_continue`) between `NUM_REQ` requesters.
- Uses round-robin arbitration and runs exactly one kernel transaction at a time, steering operand/result muxes via `sel`.
- Adds a per-transaction watchdog and optional latency instrumentation.
- Sits between the requester fabric and the kernel top, in the same clock domain.

## Interface
Parameters:
- `NUM_REQ`, 4, number of requesters (2..16)
- `TIMEOUT`, 1024, max cycles from `ap_start` rise to `ap_done` before abort
- `LAT_W`, 16, latency counter width

Ports:
- `clock` in 1: single clock, rising edge
- `reset` in 1: synchronous, active-high
- `req` in NUM_REQ: level request; held until matching `req_done`
- `req_done` out NUM_REQ: one-hot, 1-cycle completion pulse
- `req_err` out 1: qualifies `req_done`; 1 = aborted by timeout
- `sel` out $clog2(NUM_REQ): granted requester index; stable from grant until DONE exits
- `ap_start` out 1: kernel start
- `ap_ready` in 1: kernel accepted inputs
- `ap_done` in 1: kernel result valid (held until `ap_continue`)
- `ap_continue` out 1: 1-cycle done acknowledge
- `busy` out 1: state != IDLE
- `timeout_err` out 1: sticky; set on any abort; cleared only by reset
- `last_latency` out LAT_W: cycles of last completed transaction
- `max_latency` out LAT_W: largest `last_latency` since reset

## Operation
- FSM states: IDLE, START, WAIT_DONE, DONE, ABORT.
- IDLE:
  - If any `req` bit is set, the arbiter picks the first set bit strictly after `last_grant`, wrapping around.
  - Latches `sel`, updates `last_grant`, goes to START.
  - With no requests, stays in IDLE.
- START: `ap_start`=1.
  - `ap_ready` && `ap_done` in the same cycle → DONE.
  - `ap_ready` alone → WAIT_DONE.
  - Otherwise stays in START.
- WAIT_DONE: `ap_start`=0. `ap_done` → DONE.
- DONE (1 cycle):
  - `ap_continue`=1.
  - `req_done[sel]`=1, `req_err`=0.
  - Updates `last_latency`/`max_latency`.
  - → IDLE.
- ABORT (1 cycle), entered from START or WAIT_DONE when watchdog == `TIMEOUT`-1 and `ap_done`=0:
  - `ap_start`=0, `ap_continue`=1 (flushes any late done).
  - `req_done[sel]`=1, `req_err`=1, `timeout_err` set.
  - → IDLE.
- `ap_done` on the same cycle as the timeout: done wins, no error.
- Watchdog:
  - Cleared in IDLE.
  - Increments every cycle in START/WAIT_DONE.
  - Width is $clog2(TIMEOUT+1).
- Latency: cycles from the first START cycle through the cycle `ap_done` is sampled, inclusive. Saturates at 2^LAT_W-1.
- `req` deasserted before grant: ignored, no state kept. Deasserted after grant: transaction still completes and `req_done` still pulses.
- `ap_done` seen in IDLE (spurious): ignored; `ap_continue` stays 0.
- Outputs are registered except `ap_start`, `ap_continue`, `req_done`, `req_err`, which are decoded from state plus `sel`.

## Timing
- Reset values:
  - state=IDLE; all outputs 0; `last_grant`=NUM_REQ-1, so requester 0 wins first.
  - Counters and `timeout_err` = 0.
- `reset` mid-transaction: next cycle `ap_start`=0 and `ap_continue`=0. No `req_done` is issued for the interrupted transaction.
- `req` sampled at cycle T in IDLE → `ap_start`=1 at T+1.
- `ap_ready`+`ap_done` at cycle R → `req_done` and `ap_continue` at R+1 → next grant decision at R+2, `ap_start` at R+3.
- Minimum issue interval is 3 cycles.
- Worst-case wait for a requester holding `req`: (NUM_REQ-1) transactions.

## Configuration
- `MAC_KERNEL_SCHED_PERF_EN` defined: latency counter, `last_latency`, `max_latency` implemented.
- Not defined: counter logic removed; `last_latency` and `max_latency` tied to 0. Ports remain.
- Watchdog, arbitration and FSM are unaffected either way.

## Structure
- Package `mac_kernel_sched_pkg` holds:
  - the FSM state enum `sched_state_t`
  - `LAT_SAT` helper constant
  - the default `TIMEOUT` value
- Sub-module `rr_arbiter` (parameter `N`):
  - inputs `req[N]`, `last_grant`; outputs `grant_idx`, `grant_valid`
  - purely combinational; the pointer register lives in the scheduler

## Test plan
- Single request: `req`=0001, kernel `ap_ready` after 2 cycles, `ap_done` 48 cycles later.
  - Expect `req_done`=0001 and `req_err`=0.
  - With PERF: `last_latency`=51.
- Fairness: `req`=1111 held constant for 8 transactions → `sel` sequence 0,1,2,3,0,1,2,3.
- Same-cycle ready+done: kernel asserts both in the first START cycle → DONE next cycle; `last_latency`=1.
- Timeout: `TIMEOUT`=16, kernel never asserts `ap_done`.
  - ABORT at cycle 16 after start: `req_done` with `req_err`=1, `timeout_err`=1.
  - Next request still serviced normally.
- Done vs. timeout collision: `ap_done` at watchdog=`TIMEOUT`-1 → `req_err`=0, `timeout_err` stays 0.
- Reset in WAIT_DONE → outputs 0 next cycle, no `req_done`; after reset, requester 0 granted first.
